// File: rtl/mc_sequencer.sv
// mc_sequencer: multi-cycle control sequencer for the miniRV core.
// It steps each instruction through IF/ID/EX/MEM/WB, handshakes with the
// instruction and data memories, gates the decoder's write enables and
// counts retired instructions. It traps on illegal opcodes and memory timeouts.
//
// Handshake: a request (imem_req / dmem_req) is held high for the whole
// IF / MEM state. The cycle in which the matching ack is high completes the
// transfer. An ack seen outside its own state is ignored. If the ack has not
// arrived by the TIMEOUT-th request cycle, the sequencer goes to ERR.
module mc_sequencer #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [31:0]      ins,
    input  logic             imem_ack,
    input  logic             dmem_ack,
    input  logic             halt,
    input  logic             dec_rf_wen,
    output logic             imem_req,
    output logic             dmem_req,
    output logic             dmem_we,
    output logic             ir_wen,
    output logic             pc_wen,
    output logic             rf_wen,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] instret,
    output logic             illegal,
    output logic             bus_err
);

    typedef enum logic [2:0] {
        S_IF   = 3'd0,
        S_ID   = 3'd1,
        S_EX   = 3'd2,
        S_MEM  = 3'd3,
        S_WB   = 3'd4,
        S_HALT = 3'd5,
        S_TRAP = 3'd6,
        S_ERR  = 3'd7
    } state_t;

    localparam int WC_W = $clog2(TIMEOUT + 1);
    localparam logic [WC_W-1:0] WAIT_LAST = WC_W'(TIMEOUT - 1);

    state_t          state_q, state_nxt;
    logic [WC_W-1:0] wait_cnt;
    logic            imem_req_c, dmem_req_c, dmem_we_c;
    logic            ir_wen_c, pc_wen_c, rf_wen_c;
    logic            retire;

    // Opcode classification. Only the low 7 bits of IR matter here.
    logic [6:0] op;
    logic       is_load, is_store, is_branch, is_legal;
    logic       unused_ins;

    assign op         = ins[6:0];
    assign unused_ins = ^ins[31:7];
    assign is_load    = (op == 7'b0000011);
    assign is_store   = (op == 7'b0100011);
    assign is_branch  = (op == 7'b1100011);
    assign is_legal   = is_load | is_store | is_branch
                      | (op == 7'b0110011) | (op == 7'b0010011)
                      | (op == 7'b0110111) | (op == 7'b0010111)
                      | (op == 7'b1101111) | (op == 7'b1100111);

    // Next-state and Mealy output decode.
    always_comb begin
        state_nxt  = state_q;
        imem_req_c = 1'b0;
        dmem_req_c = 1'b0;
        dmem_we_c  = 1'b0;
        ir_wen_c   = 1'b0;
        pc_wen_c   = 1'b0;
        rf_wen_c   = 1'b0;
        retire     = 1'b0;
        case (state_q)
            S_IF: begin
                imem_req_c = 1'b1;
                if (imem_ack) begin
                    ir_wen_c  = 1'b1;
                    state_nxt = S_ID;
                end else if (wait_cnt == WAIT_LAST) begin
                    state_nxt = S_ERR;
                end
            end
            S_ID: state_nxt = is_legal ? S_EX : S_TRAP;
            S_EX: begin
                if (is_load || is_store) state_nxt = S_MEM;
                else if (is_branch)      retire    = 1'b1;
                else                     state_nxt = S_WB;
            end
            S_MEM: begin
                dmem_req_c = 1'b1;
                dmem_we_c  = is_store;
                if (dmem_ack) begin
                    if (is_store) retire    = 1'b1;
                    else          state_nxt = S_WB;
                end else if (wait_cnt == WAIT_LAST) begin
                    state_nxt = S_ERR;
                end
            end
            S_WB: begin
                rf_wen_c = dec_rf_wen;
                retire   = 1'b1;
            end
            S_HALT:  if (!halt) state_nxt = S_IF;
            default: state_nxt = state_q;  // TRAP and ERR hold until reset
        endcase
        // The retire cycle is also the instruction boundary where halt is sampled.
        if (retire) begin
            pc_wen_c  = 1'b1;
            state_nxt = halt ? S_HALT : S_IF;
        end
    end

    // Combinational outputs are forced low while reset is asserted.
    assign imem_req = rst_n & imem_req_c;
    assign dmem_req = rst_n & dmem_req_c;
    assign dmem_we  = rst_n & dmem_we_c;
    assign ir_wen   = rst_n & ir_wen_c;
    assign pc_wen   = rst_n & pc_wen_c;
    assign rf_wen   = rst_n & rf_wen_c;
    assign state    = state_q;

    // State register, wait counter, retire counter and sticky error flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IF;
            wait_cnt <= '0;
            instret  <= '0;
            illegal  <= 1'b0;
            bus_err  <= 1'b0;
        end else begin
            state_q <= state_nxt;
            // Any state change restarts the count, so entering IF or MEM starts at 0.
            if (state_nxt != state_q)
                wait_cnt <= '0;
            else if ((imem_req_c && !imem_ack) || (dmem_req_c && !dmem_ack))
                wait_cnt <= wait_cnt + WC_W'(1);
            if (retire)
                instret <= instret + CNT_W'(1);
            if (state_q == S_ID && state_nxt == S_TRAP)
                illegal <= 1'b1;
            if (state_q != S_ERR && state_nxt == S_ERR)
                bus_err <= 1'b1;
        end
    end

endmodule
